// File: rtl/cpu_ctrl_pkg.sv
// Shared control-block definitions: hazard FSM states, register-zero constant,
// default drain length and performance-counter width.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2,
    DRAIN  = 2'd3
  } ctrlState_t;

  localparam logic [3:0] REG_ZERO = 4'd0;

  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_CNT_W        = 16;

  // A source depends on a producer only when it is really read, the producer
  // really writes it, and the register is not the hardwired zero.
  function automatic logic regMatch(input logic qual, input logic [3:0] src,
                                    input logic [3:0] rd, input logic flag);
    return qual && flag && (rd != REG_ZERO) && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational dependency check for the ID instruction: returns the number of
// stall cycles (0..2) that EX-stage forwarding cannot hide.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] Rs_ID,
  input  logic [3:0] Rt_ID,
  input  logic       UsesRs_ID,
  input  logic       UsesRt_ID,
  input  logic       BranchReg_ID,
  input  logic [3:0] Rd_EX,
  input  logic       RegWrite_EX,
  input  logic       MemRead_EX,
  input  logic [3:0] Rd_MEM,
  input  logic       MemRead_MEM,
  output logic [1:0] stallK
);

  logic loadUse;
  logic branchEx;
  logic branchMem;

  always_comb begin
    loadUse   = regMatch(UsesRs_ID, Rs_ID, Rd_EX, MemRead_EX) ||
                regMatch(UsesRt_ID, Rt_ID, Rd_EX, MemRead_EX);
    // Branches compare in ID, so any EX producer (ALU or load) blocks them.
    branchEx  = regMatch(BranchReg_ID, Rs_ID, Rd_EX, RegWrite_EX || MemRead_EX) ||
                regMatch(BranchReg_ID, Rt_ID, Rd_EX, RegWrite_EX || MemRead_EX);
    branchMem = regMatch(BranchReg_ID, Rs_ID, Rd_MEM, MemRead_MEM) ||
                regMatch(BranchReg_ID, Rt_ID, Rd_MEM, MemRead_MEM);

    // NOTE: stallK gets a default first so no path through this block can infer a latch.
    stallK = 2'd0;
    if (loadUse || branchMem || (branchEx && !MemRead_EX)) stallK = 2'd1;
    if (branchEx && MemRead_EX) stallK = 2'd2;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/freeze/drain controller for the 5-stage CPU.
// Optional stall performance counter: define HAZARD_PERF_CNT_EN.
module hazard_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Rs_ID,
  input  logic [3:0]       Rt_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             BranchReg_ID,
  input  logic             BranchTaken_ID,
  input  logic             Halt_ID,
  input  logic [3:0]       Rd_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [3:0]       Rd_MEM,
  input  logic             MemRead_MEM,
  input  logic             IMemBusy,
  input  logic             DMemBusy,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             Freeze,
  output logic             Halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCount
`endif
);

  localparam int CB = ($clog2(DRAIN_CYCLES) < 2) ? 2 : $clog2(DRAIN_CYCLES);
  // The HLT acceptance cycle is the first drain cycle, so it is not counted again.
  localparam logic [CB-1:0] DRAIN_LOAD = CB'(DRAIN_CYCLES - 2);

  ctrlState_t    state, nextState, savedState;
  logic [CB-1:0] cnt, nextCnt, savedCnt;
  logic [1:0]    stallK;
  logic          detectStall;
  logic          acceptHalt;
  logic          haltedQ;

  hazard_detect u_detect (
    .Rs_ID        (Rs_ID),
    .Rt_ID        (Rt_ID),
    .UsesRs_ID    (UsesRs_ID),
    .UsesRt_ID    (UsesRt_ID),
    .BranchReg_ID (BranchReg_ID),
    .Rd_EX        (Rd_EX),
    .RegWrite_EX  (RegWrite_EX),
    .MemRead_EX   (MemRead_EX),
    .Rd_MEM       (Rd_MEM),
    .MemRead_MEM  (MemRead_MEM),
    .stallK       (stallK)
  );

  assign detectStall = (state == RUN) && (stallK != 2'd0);
  assign acceptHalt  = (state == RUN) && Halt_ID && (stallK == 2'd0);
  assign Halted      = haltedQ;

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    unique case (state)
      RUN: begin
        // k=1 is covered entirely by the detection cycle; only k=2 needs STALL.
        if (stallK > 2'd1) begin
          nextState = STALL;
          nextCnt   = CB'(stallK - 2'd1);
        end else if (acceptHalt) begin
          nextState = DRAIN;
          nextCnt   = DRAIN_LOAD;
        end
      end
      STALL: begin
        if (cnt <= CB'(1)) begin
          nextState = RUN;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt - CB'(1);
        end
      end
      DRAIN: begin
        if (cnt != '0) nextCnt = cnt - CB'(1);
      end
      FREEZE: begin
        nextState = savedState;
        nextCnt   = savedCnt;
      end
      default: begin
        nextState = RUN;
        nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      savedState <= RUN;
      savedCnt   <= '0;
      haltedQ    <= 1'b0;
    end else if (DMemBusy) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (state != FREEZE) begin
        // A RUN cycle already acted on its detection/HLT, so save its outcome;
        // stalls and drains hold their count while frozen.
        savedState <= (state == RUN) ? nextState : state;
        savedCnt   <= (state == RUN) ? nextCnt : cnt;
      end
      state <= FREEZE;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (nextState == DRAIN && nextCnt == '0) haltedQ <= 1'b1;
    end
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    Freeze     = 1'b0;
    if (rst) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (state == FREEZE) begin
      Freeze    = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (detectStall || state == STALL) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (state == DRAIN || acceptHalt) begin
      PCWrite   = 1'b0;
      IFIDFlush = 1'b1;
    end else if (BranchTaken_ID) begin
      IFIDFlush = 1'b1;
    end else if (IMemBusy) begin
      PCWrite   = 1'b0;
      IFIDFlush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
    end else if (!PCWrite && !haltedQ && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; expected output vectors are
// written out by hand from the hazard rules and output priority.
module tb_hazard_unit;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Rs_ID, Rt_ID, Rd_EX, Rd_MEM;
  logic       UsesRs_ID, UsesRt_ID, BranchReg_ID, BranchTaken_ID, Halt_ID;
  logic       RegWrite_EX, MemRead_EX, MemRead_MEM, IMemBusy, DMemBusy;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Freeze, Halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] StallCount;
`endif

  int checkCount = 0;
  int passCount  = 0;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Freeze}
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FRZ   = 5'b00001;
  localparam logic [4:0] O_RST   = 5'b00110;
  // {PCWrite, IFIDFlush, IDEXBubble, Freeze} for flush cases
  localparam logic [3:0] F_HOLD  = 4'b0100;
  localparam logic [3:0] F_BR    = 4'b1100;

  hazard_unit dut (
    .clk            (clk),
    .rst            (rst),
    .Rs_ID          (Rs_ID),
    .Rt_ID          (Rt_ID),
    .UsesRs_ID      (UsesRs_ID),
    .UsesRt_ID      (UsesRt_ID),
    .BranchReg_ID   (BranchReg_ID),
    .BranchTaken_ID (BranchTaken_ID),
    .Halt_ID        (Halt_ID),
    .Rd_EX          (Rd_EX),
    .RegWrite_EX    (RegWrite_EX),
    .MemRead_EX     (MemRead_EX),
    .Rd_MEM         (Rd_MEM),
    .MemRead_MEM    (MemRead_MEM),
    .IMemBusy       (IMemBusy),
    .DMemBusy       (DMemBusy),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IFIDFlush      (IFIDFlush),
    .IDEXBubble     (IDEXBubble),
    .Freeze         (Freeze),
    .Halted         (Halted)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount     (StallCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [4:0] allOut();
    return {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Freeze};
  endfunction

  function automatic logic [3:0] flushOut();
    return {PCWrite, IFIDFlush, IDEXBubble, Freeze};
  endfunction

  task automatic clearIn();
    Rs_ID = 0; Rt_ID = 0; Rd_EX = 0; Rd_MEM = 0;
    UsesRs_ID = 0; UsesRt_ID = 0; BranchReg_ID = 0; BranchTaken_ID = 0; Halt_ID = 0;
    RegWrite_EX = 0; MemRead_EX = 0; MemRead_MEM = 0; IMemBusy = 0; DMemBusy = 0;
  endtask

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearIn();
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Branch on R5 that depends on a load of R5 currently in EX.
  task automatic branchAfterLoad();
    clearIn();
    BranchReg_ID = 1; Rs_ID = 5; Rt_ID = 1; BranchTaken_ID = 1;
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 5;
  endtask

  // The load has moved to MEM and a bubble sits in EX; the branch is held in ID.
  task automatic loadToMem();
    MemRead_EX = 0; RegWrite_EX = 0; Rd_EX = 0;
    MemRead_MEM = 1; Rd_MEM = 5;
  endtask

  initial begin
    rst = 1'b1;
    clearIn();
    #2;
    check("reset_outputs", 32'(allOut()), 32'(O_RST));
    check("reset_halted", 32'(Halted), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stallcount", 32'(StallCount), 32'd0);
`endif
    nextCycle();
    rst = 1'b0;
    #1;
    check("idle_run", 32'(allOut()), 32'(O_NORM));

    // Load-use: LW R3 in EX, ADD reads R3.
    nextCycle();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 3; UsesRs_ID = 1; Rs_ID = 3; Rt_ID = 4;
    #1;
    check("loaduse_stall", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    MemRead_EX = 0; RegWrite_EX = 0; Rd_EX = 0; MemRead_MEM = 1; Rd_MEM = 3;
    #1;
    check("loaduse_resume", 32'(allOut()), 32'(O_NORM));

    // Same shape on R0: no dependency.
    nextCycle();
    clearIn();
    MemRead_EX = 1; RegWrite_EX = 1; Rd_EX = 0; UsesRs_ID = 1; Rs_ID = 0;
    #1;
    check("loaduse_r0", 32'(allOut()), 32'(O_NORM));

    // Unused source does not match.
    nextCycle();
    clearIn();
    MemRead_EX = 1; Rd_EX = 6; Rt_ID = 6; UsesRt_ID = 0;
    #1;
    check("loaduse_unused_src", 32'(allOut()), 32'(O_NORM));

    // Branch after load: 2 stall cycles, taken ignored, then flush.
    nextCycle();
    branchAfterLoad();
    #1;
    check("brload_stall1", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    loadToMem();
    #1;
    check("brload_stall2", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    MemRead_MEM = 0; Rd_MEM = 0;
    #1;
    check("brload_flush", 32'(flushOut()), 32'(F_BR));
    nextCycle();
    clearIn();
    #1;
    check("brload_after", 32'(allOut()), 32'(O_NORM));

    // Branch after ALU op writing Rt.
    nextCycle();
    BranchReg_ID = 1; Rs_ID = 2; Rt_ID = 7; RegWrite_EX = 1; Rd_EX = 7;
    #1;
    check("bralu_stall", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    RegWrite_EX = 0; Rd_EX = 0; Rd_MEM = 7;
    #1;
    check("bralu_resume", 32'(allOut()), 32'(O_NORM));

    // Branch on a load result still in MEM.
    nextCycle();
    clearIn();
    BranchReg_ID = 1; Rs_ID = 9; MemRead_MEM = 1; Rd_MEM = 9;
    #1;
    check("brmem_stall", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    MemRead_MEM = 0; Rd_MEM = 0;
    #1;
    check("brmem_resume", 32'(allOut()), 32'(O_NORM));

    // Instruction-fetch miss, and a taken branch outranking it.
    nextCycle();
    clearIn();
    IMemBusy = 1;
    #1;
    check("imem_busy", 32'(flushOut()), 32'(F_HOLD));
    BranchTaken_ID = 1;
    #1;
    check("branch_over_imem", 32'(flushOut()), 32'(F_BR));

    // Freeze in the middle of a k=2 stall.
    nextCycle();
    doReset();
    nextCycle();
    branchAfterLoad();
    BranchTaken_ID = 0;
    #1;
    check("frz_stall1", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    loadToMem();
    DMemBusy = 1;
    #1;
    check("frz_busy_stall", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    #1;
    check("frz_cycle1", 32'(allOut()), 32'(O_FRZ));
    nextCycle();
    #1;
    check("frz_cycle2", 32'(allOut()), 32'(O_FRZ));
    nextCycle();
    DMemBusy = 0;
    #1;
    check("frz_cycle3", 32'(allOut()), 32'(O_FRZ));
    nextCycle();
    #1;
    check("frz_last_stall", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    MemRead_MEM = 0; Rd_MEM = 0;
    #1;
    check("frz_resume", 32'(allOut()), 32'(O_NORM));
`ifdef HAZARD_PERF_CNT_EN
    check("frz_stallcount", 32'(StallCount), 32'd6);
`endif

    // HLT drain.
    nextCycle();
    clearIn();
    Halt_ID = 1;
    #1;
    check("hlt_accept", 32'(flushOut()), 32'(F_HOLD));
    check("hlt_not_yet", 32'(Halted), 32'd0);
    nextCycle();
    Halt_ID = 0;
    #1;
    check("hlt_drain1", 32'(flushOut()), 32'(F_HOLD));
    check("hlt_halted1", 32'(Halted), 32'd0);
    nextCycle();
    #1;
    check("hlt_halted2", 32'(Halted), 32'd0);
    nextCycle();
    #1;
    check("hlt_halted3", 32'(Halted), 32'd1);
    for (int i = 0; i < 3; i++) nextCycle();
    BranchTaken_ID = 1;
    #1;
    check("hlt_sticky", 32'(Halted), 32'd1);
    check("hlt_drain_over_branch", 32'(flushOut()), 32'(F_HOLD));
    #2;
    rst = 1'b1;
    #1;
    check("hlt_async_clear", 32'(Halted), 32'd0);
    check("hlt_rst_outputs", 32'(allOut()), 32'(O_RST));
    nextCycle();
    rst = 1'b0;
    clearIn();

    // Reset during a k=2 stall.
    nextCycle();
    branchAfterLoad();
    #1;
    check("rststall_stall1", 32'(allOut()), 32'(O_STALL));
    nextCycle();
    loadToMem();
    #2;
    rst = 1'b1;
    #1;
    check("rststall_outputs", 32'(allOut()), 32'(O_RST));
    nextCycle();
    rst = 1'b0;
    clearIn();
    #1;
    check("rststall_run1", 32'(allOut()), 32'(O_NORM));
    nextCycle();
    #1;
    check("rststall_run2", 32'(allOut()), 32'(O_NORM));
    check("rststall_halted", 32'(Halted), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline stall/flush controller for the 5-stage, 16-register CPU; it handles every hazard that EX-stage operand forwarding cannot. It detects load-use and branch-operand dependencies in ID and commits multi-cycle stalls. It also freezes the whole pipeline on multi-cycle memory accesses, injects bubbles on taken branches and instruction-fetch misses, and drains the pipeline on HLT. It sits in the Control block beside the forwarding logic and drives the PC and pipeline-register enables.

## Interface
- DRAIN_CYCLES, 4: cycles from HLT acceptance in ID to `Halted` assertion.
- CNT_W, 16: width of the stall performance counter.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs_ID, Rt_ID  in  4 each  source registers of the instruction in ID.
- UsesRs_ID, UsesRt_ID  in  1 each  the ID instruction actually reads that source.
- BranchReg_ID  in  1  ID instruction is a register-compare branch (resolved in ID).
- BranchTaken_ID  in  1  branch in ID resolved taken.
- Halt_ID  in  1  HLT opcode in ID.
- Rd_EX  in  4  destination register of the instruction in EX.
- RegWrite_EX  in  1  write-enable of the instruction in EX.
- MemRead_EX  in  1  the EX instruction is a load.
- Rd_MEM  in  4  destination register of the instruction in MEM.
- MemRead_MEM  in  1  the MEM instruction is a load.
- IMemBusy, DMemBusy  in  1 each  instruction/data memory not ready this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  load NOP into IF/ID.
- IDEXBubble  out  1  load NOP control into ID/EX.
- Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- Halted  out  1  pipeline drained after HLT; sticky until reset.
- StallCount  out  CNT_W  stall cycles counted (present only with the macro).

## Operation
- Register 0 never creates a dependency. A source matches only if its Uses*/BranchReg qualifier is set and it equals a nonzero Rd with the corresponding write/read flag.
- Required stall k, evaluated only in RUN with the stall counter at 0:
  - Load-use: MemRead_EX and a source matches Rd_EX gives k=1.
  - BranchReg_ID and a source matches Rd_EX: with MemRead_EX, k=2; otherwise, with RegWrite_EX, k=1.
  - BranchReg_ID, MemRead_MEM and a source matches Rd_MEM gives k=1.
  - k is the maximum of all applicable rules.
- FSM states are RUN, STALL, FREEZE and DRAIN (Halted is DRAIN with the counter done).
  - RUN → STALL when k>0. The stall counter loads k-1 and the detection cycle is itself stalled.
  - STALL decrements the counter each unfrozen cycle and returns to RUN when the counter is 0. Dependency rechecks are suppressed while in STALL.
  - Any state → FREEZE when DMemBusy. The prior state and counter are saved. On the first cycle with DMemBusy low, the FSM returns to the saved state.
  - RUN with Halt_ID and k=0 → DRAIN, drain counter = DRAIN_CYCLES-1. Halted asserts when it reaches 0.
- Output priority, highest first:
  - FREEZE: Freeze=1, PCWrite=0, IFIDWrite=0, no flush, no bubble.
  - Stall (detection cycle or STALL): PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - DRAIN: PCWrite=0, IFIDFlush=1.
  - BranchTaken_ID in RUN: IFIDFlush=1 (PC loads the target).
  - IMemBusy: PCWrite=0, IFIDFlush=1.
  - Otherwise: PCWrite=1, IFIDWrite=1, all others 0.
- BranchTaken_ID is ignored during a stall; the branch re-resolves when unstalled.
- Halt_ID during a stall is accepted only after the stall ends.

## Timing
- Outputs are Mealy: the detection cycle responds combinationally in the same cycle. State, counters and Halted are registered.
- Stall lengths are exact: k=1 means 1 cycle with PCWrite=0; k=2 means 2 cycles, excluding freeze cycles.
- DMemBusy going high mid-stall extends the stall by the busy duration. The counter does not decrement while frozen.
- Reset (asynchronous) state: RUN, counters 0, Halted=0, StallCount=0.
- Outputs while rst is high: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, Freeze=0.
- Reset asserted mid-stall or mid-drain aborts it immediately.

## Configuration
- HAZARD_PERF_CNT_EN defined: StallCount increments on every cycle with PCWrite=0 while not in reset and not Halted. It saturates at all-ones.
- HAZARD_PERF_CNT_EN undefined: the StallCount port and counter are absent.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the FSM state enum (RUN, STALL, FREEZE, DRAIN);
  - REG_ZERO = 4'd0;
  - default DRAIN_CYCLES and CNT_W.
- One combinational sub-module, hazard_detect, computes k from the ID/EX/MEM fields. The hazard_unit top owns the FSM, the counters and the output priority.

## Test plan
- Load-use: `LW R3` in EX (MemRead_EX=1, Rd_EX=3) with an ADD in ID reading Rs=3.
  - Exactly 1 cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1, then normal flow.
  - The same sequence with Rd_EX=0 → no stall.
- Branch after load: BranchReg_ID=1, Rs_ID=5, MemRead_EX=1, Rd_EX=5.
  - 2 stall cycles.
  - BranchTaken_ID asserted during them produces no flush; in the first unstalled cycle, IFIDFlush=1.
- Branch after ALU op: BranchReg_ID=1, RegWrite_EX=1, MemRead_EX=0, Rd_EX=7 = Rt_ID → 1 stall cycle.
- Freeze mid-stall: k=2 stall with DMemBusy high for 3 cycles after the first stall cycle.
  - Freeze=1 for those 3 cycles, then 1 more stall cycle, for 6 cycles total with PCWrite=0.
  - With HAZARD_PERF_CNT_EN, StallCount=6.
- HLT: Halt_ID=1 with no hazard.
  - PCWrite=0 and IFIDFlush=1 from that cycle.
  - Halted=1 DRAIN_CYCLES-1=3 cycles later and stays high.
  - Asynchronous rst clears it immediately.
- Reset mid-stall: assert rst during a k=2 stall.
  - Reset outputs are applied immediately.
  - After release, the FSM is in RUN with no residual stall.
